// File: rtl/spi_sram_target.sv
// spi_sram_target: SPI mode-0 responder serving a word-addressed 16-bit RAM.
// The CS/SCLK/MOSI pins are oversampled on i_clk. The block decodes READ and WRITE frames:
// an 8-bit command, a 16-bit word address, then 16-bit data words. Accesses auto-increment,
// so a frame can carry a sequential burst.
// Ports:
//   i_clk          oversampling clock (>= 8x SCLK)
//   i_rst_n        asynchronous reset, active low
//   i_spi_cs_n     chip select, active low, asynchronous
//   i_spi_clk      SCLK, mode 0, asynchronous
//   i_spi_mosi     serial data in, MSB first
//   o_spi_miso     serial data out, MSB first
//   o_spi_miso_oe  high while read data is being driven
//   o_frame_err    one-cycle pulse on an unknown command byte
//   o_word_done    one-cycle pulse per completed 16-bit data word
module spi_sram_target #(
  parameter int unsigned ADDR_BITS = 4,
  parameter logic [7:0]  CMD_READ  = 8'h03,
  parameter logic [7:0]  CMD_WRITE = 8'h02
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_spi_cs_n,
  input  logic i_spi_clk,
  input  logic i_spi_mosi,
  output logic o_spi_miso,
  output logic o_spi_miso_oe,
  output logic o_frame_err,
  output logic o_word_done
);

  localparam int unsigned DEPTH = 2 ** ADDR_BITS;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CMD    = 3'd1;
  localparam logic [2:0] ST_ADDR   = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_IGNORE = 3'd4;

  logic r_cs_meta, r_cs_sync;
  logic r_sclk_meta, r_sclk_sync, r_sclk_prev;
  logic r_mosi_meta, r_mosi_sync, r_mosi_d;
  logic r_rise, r_fall;

  logic [2:0]  r_state;
  logic [4:0]  r_bit_cnt;
  logic [15:0] r_shift_in;
  logic [15:0] r_shift_out;
  logic [15:0] r_addr;
  logic        r_is_read;
  logic        r_miso, r_miso_oe, r_frame_err, r_word_done;

  logic [15:0] r_mem [DEPTH];

  logic        w_sclk_rise, w_sclk_fall;
  logic [15:0] w_shift_next;
  logic [15:0] w_addr_next;
  logic        w_last_bit;
  logic        w_mem_we;

  // Edges are gated by the synchronised CS so that a rise coinciding with CS-high is dropped.
  assign w_sclk_rise  = r_sclk_sync & ~r_sclk_prev & ~r_cs_sync;
  assign w_sclk_fall  = ~r_sclk_sync & r_sclk_prev & ~r_cs_sync;
  assign w_shift_next = {r_shift_in[14:0], r_mosi_d};
  assign w_addr_next  = r_addr + 16'd1;
  assign w_last_bit   = (r_bit_cnt == 5'd15);
  assign w_mem_we     = (r_state == ST_DATA) & ~r_cs_sync & r_rise & ~r_is_read & w_last_bit;

  // Synchronisers plus a registered edge-detect stage; r_mosi_d keeps data aligned with r_rise.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cs_meta   <= 1'b1;
      r_cs_sync   <= 1'b1;
      r_sclk_meta <= 1'b0;
      r_sclk_sync <= 1'b0;
      r_sclk_prev <= 1'b0;
      r_mosi_meta <= 1'b0;
      r_mosi_sync <= 1'b0;
      r_mosi_d    <= 1'b0;
      r_rise      <= 1'b0;
      r_fall      <= 1'b0;
    end else begin
      r_cs_meta   <= i_spi_cs_n;
      r_cs_sync   <= r_cs_meta;
      r_sclk_meta <= i_spi_clk;
      r_sclk_sync <= r_sclk_meta;
      r_sclk_prev <= r_sclk_sync;
      r_mosi_meta <= i_spi_mosi;
      r_mosi_sync <= r_mosi_meta;
      r_mosi_d    <= r_mosi_sync;
      r_rise      <= w_sclk_rise;
      r_fall      <= w_sclk_fall;
    end
  end

  // Memory contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (w_mem_we) r_mem[r_addr[ADDR_BITS-1:0]] <= w_shift_next;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= 5'd0;
      r_shift_in  <= 16'd0;
      r_shift_out <= 16'd0;
      r_addr      <= 16'd0;
      r_is_read   <= 1'b0;
      r_miso      <= 1'b0;
      r_miso_oe   <= 1'b0;
      r_frame_err <= 1'b0;
      r_word_done <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      r_word_done <= 1'b0;
      if (r_cs_sync) begin
        r_state   <= ST_IDLE;
        r_miso    <= 1'b0;
        r_miso_oe <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_bit_cnt <= 5'd0;
            r_state   <= ST_CMD;
          end
          ST_CMD: begin
            if (r_rise) begin
              r_shift_in <= w_shift_next;
              r_bit_cnt  <= r_bit_cnt + 5'd1;
              if (r_bit_cnt == 5'd7) begin
                r_bit_cnt <= 5'd0;
                if (w_shift_next[7:0] == CMD_READ || w_shift_next[7:0] == CMD_WRITE) begin
                  r_is_read <= (w_shift_next[7:0] == CMD_READ);
                  r_state   <= ST_ADDR;
                end else begin
                  r_frame_err <= 1'b1;
                  r_state     <= ST_IGNORE;
                end
              end
            end
          end
          ST_ADDR: begin
            if (r_rise) begin
              r_shift_in <= w_shift_next;
              r_bit_cnt  <= r_bit_cnt + 5'd1;
              if (w_last_bit) begin
                r_addr    <= w_shift_next;
                r_bit_cnt <= 5'd0;
                r_state   <= ST_DATA;
                r_miso_oe <= r_is_read;
                if (r_is_read) r_shift_out <= r_mem[w_shift_next[ADDR_BITS-1:0]];
              end
            end
          end
          ST_DATA: begin
            r_miso_oe <= r_is_read;
            if (r_rise) begin
              r_shift_in <= w_shift_next;
              r_bit_cnt  <= r_bit_cnt + 5'd1;
              if (w_last_bit) begin
                r_bit_cnt   <= 5'd0;
                r_word_done <= 1'b1;
                r_addr      <= w_addr_next;
                // Prefetch the next word so its MSB is ready on the following fall.
                if (r_is_read) r_shift_out <= r_mem[w_addr_next[ADDR_BITS-1:0]];
              end
            end else if (r_fall && r_is_read) begin
              r_miso      <= r_shift_out[15];
              r_shift_out <= {r_shift_out[14:0], 1'b0};
            end
          end
          ST_IGNORE: begin
            r_miso_oe <= 1'b0;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_spi_miso    = r_miso;
  assign o_spi_miso_oe = r_miso_oe;
  assign o_frame_err   = r_frame_err;
  assign o_word_done   = r_word_done;

endmodule

// File: tb/tb_spi_sram_target.sv
// Bench for spi_sram_target: directed and random SPI frames checked against an array model.
module tb_spi_sram_target;

  localparam int HALF = 8;  // SCLK half period in clk cycles

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cs_n = 1'b1;
  logic sclk = 1'b0;
  logic mosi = 1'b0;
  logic miso, miso_oe, frame_err, word_done;

  int n_checks = 0;
  int n_fail = 0;
  int wd_cnt = 0;
  int fe_cnt = 0;

  logic [15:0] ref_mem [16];

  spi_sram_target #(
    .ADDR_BITS(4),
    .CMD_READ (8'h03),
    .CMD_WRITE(8'h02)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_spi_cs_n   (cs_n),
    .i_spi_clk    (sclk),
    .i_spi_mosi   (mosi),
    .o_spi_miso   (miso),
    .o_spi_miso_oe(miso_oe),
    .o_frame_err  (frame_err),
    .o_word_done  (word_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (word_done === 1'b1) wd_cnt <= wd_cnt + 1;
    if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
  end

  initial begin
    #3ms;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One SCLK period; called at a clk negedge with sclk low. MISO is sampled just before the rise.
  task automatic spi_bit(input logic b, output logic m, output logic oe);
    mosi = b;
    repeat (HALF) @(negedge clk);
    m  = miso;
    oe = miso_oe;
    sclk = 1'b1;
    repeat (HALF) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic cs_begin();
    @(negedge clk);
    cs_n = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic cs_end();
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    mosi = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  // Full frame: command, address (only for known commands), then ndata data bits from wbits.
  task automatic frame(input logic [7:0] cmd, input logic [15:0] addr, input int ndata,
                       input logic [63:0] wbits, output logic [63:0] rbits, output int oe_err);
    logic m, o;
    logic oe_exp;
    oe_err = 0;
    rbits  = '0;
    oe_exp = (cmd == 8'h03);
    cs_begin();
    for (int i = 0; i < 8; i++) begin
      spi_bit(cmd[7-i], m, o);
      if (o !== 1'b0) oe_err++;
    end
    if (cmd == 8'h02 || cmd == 8'h03) begin
      for (int i = 0; i < 16; i++) begin
        spi_bit(addr[15-i], m, o);
        if (o !== 1'b0) oe_err++;
      end
    end
    for (int i = 0; i < ndata; i++) begin
      spi_bit(wbits[63-i], m, o);
      rbits[63-i] = m;
      if (o !== oe_exp) oe_err++;
    end
    cs_end();
  endtask

  task automatic write_burst(input string tag, input logic [15:0] addr, input int n,
                             input logic [63:0] words);
    logic [63:0] rb;
    int oe_err;
    int d0;
    logic [3:0] idx;
    d0 = wd_cnt;
    frame(8'h02, addr, 16 * n, words, rb, oe_err);
    for (int i = 0; i < n; i++) begin
      idx = addr[3:0] + 4'(i);
      ref_mem[idx] = words[63-16*i -: 16];
    end
    check({tag, "_wd"}, 64'(wd_cnt - d0), 64'(n));
    check({tag, "_oe"}, 64'(oe_err), 64'd0);
  endtask

  task automatic read_check(input string tag, input logic [15:0] addr, input int n);
    logic [63:0] rb;
    logic [63:0] exp;
    int oe_err;
    int d0;
    logic [3:0] idx;
    exp = '0;
    for (int i = 0; i < n; i++) begin
      idx = addr[3:0] + 4'(i);
      exp[63-16*i -: 16] = ref_mem[idx];
    end
    d0 = wd_cnt;
    frame(8'h03, addr, 16 * n, 64'd0, rb, oe_err);
    check({tag, "_data"}, rb, exp);
    check({tag, "_wd"}, 64'(wd_cnt - d0), 64'(n));
    check({tag, "_oe"}, 64'(oe_err), 64'd0);
    check({tag, "_oe_idle"}, 64'(miso_oe), 64'd0);
  endtask

  initial begin
    logic [63:0] rb;
    logic [63:0] w;
    logic [63:0] junk;
    logic [15:0] a;
    int oe_err;
    int d0;
    int f0;
    int n;
    logic m, o;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_miso", 64'(miso), 64'd0);
    check("rst_oe", 64'(miso_oe), 64'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_frame_err", 64'(frame_err), 64'd0);
    check("rst_word_done", 64'(word_done), 64'd0);

    // Fill the whole memory so the model is defined everywhere
    for (int base = 0; base < 16; base += 4) begin
      w = {$urandom, $urandom};
      write_burst("fill", 16'(base), 4, w);
    end
    read_check("fill_rd", 16'h0000, 4);

    // Write then read
    write_burst("wr_beef", 16'h0003, 1, {16'hBEEF, 48'd0});
    read_check("rd_beef", 16'h0003, 1);

    // Burst write wrapping past the top of memory
    write_burst("wrap_wr", 16'h000F, 2, {16'h1111, 16'h2222, 32'd0});
    read_check("wrap_rd0", 16'h0000, 1);
    read_check("wrap_rdF", 16'h000F, 1);

    // Upper address bits alias
    write_burst("alias_wr", 16'h8005, 1, {16'hA5A5, 48'd0});
    read_check("alias_rd", 16'h0005, 1);

    // Unknown command followed by 32 random bits
    d0 = wd_cnt;
    f0 = fe_cnt;
    junk = {$urandom, 32'd0};
    frame(8'h9F, 16'h0000, 32, junk, rb, oe_err);
    check("badcmd_fe", 64'(fe_cnt - f0), 64'd1);
    check("badcmd_wd", 64'(wd_cnt - d0), 64'd0);
    check("badcmd_oe", 64'(oe_err), 64'd0);
    read_check("badcmd_rd0", 16'h0000, 4);
    read_check("badcmd_rd4", 16'h0004, 4);
    read_check("badcmd_rd8", 16'h0008, 4);
    read_check("badcmd_rdC", 16'h000C, 4);

    // Abort after 9 data bits: partial word must not land
    d0 = wd_cnt;
    frame(8'h02, 16'h0002, 9, {$urandom, $urandom}, rb, oe_err);
    check("abort_wd", 64'(wd_cnt - d0), 64'd0);
    read_check("abort_rd", 16'h0002, 1);

    // Async reset in the middle of read data
    write_burst("ones_wr", 16'h0007, 1, {16'hFFFF, 48'd0});
    cs_begin();
    for (int i = 0; i < 8; i++) spi_bit(1'(8'h03 >> (7 - i)), m, o);
    for (int i = 0; i < 16; i++) spi_bit(1'(16'h0007 >> (15 - i)), m, o);
    for (int i = 0; i < 4; i++) spi_bit(1'b0, m, o);
    repeat (6) @(negedge clk);
    check("prerst_oe", 64'(miso_oe), 64'd1);
    check("prerst_miso", 64'(miso), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_miso", 64'(miso), 64'd0);
    check("arst_oe", 64'(miso_oe), 64'd0);
    cs_n = 1'b1;
    sclk = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    d0 = wd_cnt;
    f0 = fe_cnt;
    for (int i = 0; i < 20; i++) spi_bit(1'($urandom), m, o);
    check("postrst_oe", 64'(miso_oe), 64'd0);
    check("postrst_wd", 64'(wd_cnt - d0), 64'd0);
    check("postrst_fe", 64'(fe_cnt - f0), 64'd0);
    read_check("postrst_rd", 16'h0007, 1);

    // Random bursts
    for (int it = 0; it < 6; it++) begin
      a = 16'($urandom);
      n = int'($urandom_range(1, 4));
      w = {$urandom, $urandom};
      write_burst("rand_wr", a, n, w);
      a = 16'($urandom);
      n = int'($urandom_range(1, 4));
      read_check("rand_rd", a, n);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
